// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one external combinational ALU
// between NUM_REQ requesters. One operation is in flight at a time:
// IDLE (grant/accept) -> EXEC (ALU evaluates registered operands) -> RESP.

package alu_pkg;
    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9,
        BYP  = 4'd10
    } aluop_t;
endpackage

module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  alu_pkg::aluop_t [NUM_REQ-1:0]   req_aluop,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opr_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_opr_b,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_result,
    output alu_pkg::aluop_t                 alu_aluop,
    output logic [DATA_WIDTH-1:0]           alu_opr_a,
    output logic [DATA_WIDTH-1:0]           alu_opr_b,
    input  logic [DATA_WIDTH-1:0]           alu_result
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                 state_q;
    logic [ID_W-1:0]        ptr_q;
    logic [ID_W-1:0]        id_q;
    alu_pkg::aluop_t        alu_aluop_q;
    logic [DATA_WIDTH-1:0]  alu_opr_a_q;
    logic [DATA_WIDTH-1:0]  alu_opr_b_q;
    logic [NUM_REQ-1:0]     rsp_valid_q;
    logic [DATA_WIDTH-1:0]  rsp_result_q;

    logic                   win_found_d;
    logic [ID_W-1:0]        win_id_d;
    logic [ID_W-1:0]        ptr_d;
    logic [NUM_REQ-1:0]     id_onehot;
    logic                   accept;

    alu_pkg::aluop_t        op_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0]  a_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  b_arr  [NUM_REQ];

    // Split the flattened request payload into per-requester lanes.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_aluop[gi];
            assign a_arr[gi]  = req_opr_a[gi*DATA_WIDTH +: DATA_WIDTH];
            assign b_arr[gi]  = req_opr_b[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Round-robin search from ptr_q; walking backwards lets the entry
    // closest to the pointer overwrite the others.
    always_comb begin
        int idx;
        win_found_d = 1'b0;
        win_id_d    = '0;
        idx         = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req_valid[ID_W'(idx)]) begin
                win_found_d = 1'b1;
                win_id_d    = ID_W'(idx);
            end
        end
    end

    // Grant is only offered in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !rst && win_found_d) begin
            req_ready[win_id_d] = 1'b1;
        end
    end

    // Pointer moves one past the winner; one-hot of the stored owner.
    always_comb begin
        ptr_d = (win_id_d == ID_W'(NUM_REQ - 1)) ? '0 : win_id_d + ID_W'(1);
        id_onehot = '0;
        id_onehot[id_q] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    // Issue FSM with registered ALU drive and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            alu_aluop_q  <= alu_pkg::ADD;
            alu_opr_a_q  <= '0;
            alu_opr_b_q  <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_aluop_q <= op_arr[win_id_d];
                        alu_opr_a_q <= a_arr[win_id_d];
                        alu_opr_b_q <= b_arr[win_id_d];
                        id_q        <= win_id_d;
                        ptr_q       <= ptr_d;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_valid_q  <= id_onehot;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (rsp_ready[id_q]) begin
                        rsp_valid_q <= '0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_aluop  = alu_aluop_q;
    assign alu_opr_a  = alu_opr_a_q;
    assign alu_opr_b  = alu_opr_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU on the
// shared ALU port. Two requesters, 32-bit data.

module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    aluop_t [1:0]       req_aluop;
    logic [63:0]        req_opr_a;
    logic [63:0]        req_opr_b;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [31:0]        rsp_result;
    aluop_t             alu_aluop;
    logic [31:0]        alu_opr_a;
    logic [31:0]        alu_opr_b;
    logic [31:0]        alu_result;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] pend_q = 2'b00;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_WIDTH(32), .NUM_REQ(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_aluop  (req_aluop),
        .req_opr_a  (req_opr_a),
        .req_opr_b  (req_opr_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .alu_aluop  (alu_aluop),
        .alu_opr_a  (alu_opr_a),
        .alu_opr_b  (alu_opr_b),
        .alu_result (alu_result)
    );

    // Reference shared ALU; undefined opcodes give 0.
    always_comb begin
        alu_result = '0;
        case (alu_aluop)
            ADD:  alu_result = alu_opr_a + alu_opr_b;
            SUB:  alu_result = alu_opr_a - alu_opr_b;
            AND:  alu_result = alu_opr_a & alu_opr_b;
            OR:   alu_result = alu_opr_a | alu_opr_b;
            XOR:  alu_result = alu_opr_a ^ alu_opr_b;
            SLL:  alu_result = alu_opr_a << alu_opr_b[4:0];
            SRL:  alu_result = alu_opr_a >> alu_opr_b[4:0];
            SRA:  alu_result = $signed(alu_opr_a) >>> alu_opr_b[4:0];
            SLT:  alu_result = {31'd0, $signed(alu_opr_a) < $signed(alu_opr_b)};
            SLTU: alu_result = {31'd0, alu_opr_a < alu_opr_b};
            BYP:  alu_result = alu_opr_b;
            default: alu_result = '0;
        endcase
    end

    // A raised request must stay raised until the DUT accepts it.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (pend_q[i]) begin
                    n_checks++;
                    assert (req_valid[i] === 1'b1) else begin
                        n_fail++;
                        $error("FAIL proto_hold[%0d]: observed %b expected 1", i, req_valid[i]);
                    end
                end
            end
            pend_q <= req_valid & ~req_ready;
        end else begin
            pend_q <= 2'b00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input aluop_t op, input logic [31:0] a, input logic [31:0] b);
        req_aluop[idx]         = op;
        req_opr_a[idx*32 +: 32] = a;
        req_opr_b[idx*32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete operation from a single requester with rsp_ready high.
    // Starts and ends on a negedge in IDLE.
    task automatic run_op(input string tag, input int idx, input aluop_t op,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        logic [1:0] oh;
        oh = 2'b01 << idx;
        set_req(idx, op, a, b);
        req_valid = oh;
        rsp_ready = 2'b11;
        #1 check({tag, "/req_ready"}, 32'(req_ready), 32'(oh));
        @(negedge clk);
        check({tag, "/alu_aluop"}, 32'(alu_aluop), 32'(op));
        check({tag, "/alu_opr_a"}, alu_opr_a, a);
        check({tag, "/alu_opr_b"}, alu_opr_b, b);
        check({tag, "/exec_ready"}, 32'(req_ready), 32'd0);
        check({tag, "/exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'(oh));
        check({tag, "/rsp_result"}, rsp_result, exp);
        @(negedge clk);
        check({tag, "/idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  oh;
        int          g;
        rst        = 1'b1;
        req_valid  = 2'b00;
        rsp_ready  = 2'b00;
        req_aluop  = {ADD, ADD};
        req_opr_a  = '0;
        req_opr_b  = '0;

        // Reset values
        #1;
        check("rst/rsp_valid",  32'(rsp_valid), 32'd0);
        check("rst/rsp_result", rsp_result, 32'd0);
        check("rst/alu_aluop",  32'(alu_aluop), 32'(ADD));
        check("rst/alu_opr_a",  alu_opr_a, 32'd0);
        check("rst/alu_opr_b",  alu_opr_b, 32'd0);
        req_valid = 2'b11;
        #1 check("rst/req_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst = 1'b0;

        // Single request: 5 + 7
        run_op("single_add", 0, ADD, 32'd5, 32'd7, 32'd12);

        // Contention and fairness: both requesters held valid from reset
        do_reset();
        set_req(0, SUB, 32'd10, 32'd3);
        set_req(1, XOR, 32'h000000F0, 32'h000000FF);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int op = 0; op < 6; op++) begin
            g  = op % 2;
            oh = 2'b01 << g;
            #1 check($sformatf("fair%0d/req_ready", op), 32'(req_ready), 32'(oh));
            @(negedge clk);
            check($sformatf("fair%0d/alu_aluop", op), 32'(alu_aluop), (g == 0) ? 32'(SUB) : 32'(XOR));
            if (op >= 4) begin
                req_valid[g] = 1'b0;
            end
            @(negedge clk);
            check($sformatf("fair%0d/rsp_valid", op), 32'(rsp_valid), 32'(oh));
            check($sformatf("fair%0d/rsp_result", op), rsp_result, (g == 0) ? 32'd7 : 32'h0000000F);
            @(negedge clk);
        end
        check("fair/idle_ready", 32'(req_ready), 32'd0);

        // Backpressure on requester 1, with a newcomer on requester 0
        do_reset();
        set_req(1, SLT, 32'hFFFFFFFF, 32'd1);
        req_valid = 2'b10;
        rsp_ready = 2'b00;
        #1 check("bp/req_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        check("bp/alu_aluop", 32'(alu_aluop), 32'(SLT));
        set_req(0, ADD, 32'd1, 32'd2);
        req_valid = 2'b01;
        #1 check("bp/exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 2'b01;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d/rsp_valid", i), 32'(rsp_valid), 32'h2);
            check($sformatf("bp%0d/rsp_result", i), rsp_result, 32'd1);
            check($sformatf("bp%0d/req_ready", i), 32'(req_ready), 32'd0);
            if (i == 4) begin
                rsp_ready = 2'b11;
            end
            @(negedge clk);
        end
        check("bp/release_rsp_valid", 32'(rsp_valid), 32'd0);
        check("bp/next_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("bp/next_opr_a", alu_opr_a, 32'd1);
        req_valid = 2'b00;
        @(negedge clk);
        check("bp/next_rsp_valid", 32'(rsp_valid), 32'h1);
        check("bp/next_result", rsp_result, 32'd3);
        @(negedge clk);

        // Pass-through of unusual opcodes
        run_op("undef_op", 0, aluop_t'(4'hF), 32'd5, 32'd6, 32'd0);
        run_op("sltu", 0, SLTU, 32'hFFFFFFFF, 32'd1, 32'd0);
        run_op("byp", 1, BYP, 32'h12345678, 32'hDEADBEEF, 32'hDEADBEEF);

        // Asynchronous reset during EXEC drops the operation
        set_req(0, ADD, 32'd100, 32'd200);
        req_valid = 2'b01;
        rsp_ready = 2'b11;
        #1 check("rstx/req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        check("rstx/alu_opr_a", alu_opr_a, 32'd100);
        req_valid = 2'b00;
        #2 rst = 1'b1;
        #1;
        check("rstx/rsp_valid",  32'(rsp_valid), 32'd0);
        check("rstx/rsp_result", rsp_result, 32'd0);
        check("rstx/alu_aluop",  32'(alu_aluop), 32'(ADD));
        check("rstx/alu_opr_a",  alu_opr_a, 32'd0);
        check("rstx/alu_opr_b",  alu_opr_b, 32'd0);
        @(negedge clk);
        check("rstx/held_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rstx/after1_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("rstx/after2_rsp_valid", 32'(rsp_valid), 32'd0);
        run_op("rstx_next", 1, ADD, 32'd1, 32'd1, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
